// File: rtl/merge_serializer_if.sv
// Word-in / element-out stream bundle for merge_serializer; slave is the serializer side.
// out_last exists only when SERIALIZER_LAST_EN is defined.
interface merge_serializer_if #(
    parameter int WIDTH = 3
);
    logic [4*WIDTH-1:0] in_data;
    logic [1:0]         in_s;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   out_data;
    logic [1:0]         out_s;
    logic [1:0]         out_idx;
    logic               out_valid;
    logic               out_ready;
`ifdef SERIALIZER_LAST_EN
    logic               out_last;
`endif

    modport master (
        output in_data, in_s, in_valid, out_ready,
        input  in_ready, out_data, out_s, out_idx, out_valid
`ifdef SERIALIZER_LAST_EN
        , input out_last
`endif
    );

    modport slave (
        input  in_data, in_s, in_valid, out_ready,
        output in_ready, out_data, out_s, out_idx, out_valid
`ifdef SERIALIZER_LAST_EN
        , output out_last
`endif
    );
endinterface

// File: rtl/merge_serializer.sv
// Serializes merged words (K = in_s+1 elements) one element per clock via a 2-deep word FIFO.
// Element 0 one edge after acceptance when idle; out_ready=0 holds all out_*; SERIALIZER_LAST_EN adds out_last.
module merge_serializer #(
    parameter int WIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    merge_serializer_if.slave  ser_if
);
    localparam int WW = 4 * WIDTH;

    typedef enum logic {IDLE, EMIT} state_t;

    logic [WW+1:0] mem_q [2];
    logic          wr_ptr_q;
    logic          rd_ptr_q;
    logic [1:0]    cnt_q, cnt_d;
    state_t        state_q, state_d;
    logic [WW-1:0] word_q, word_d;
    logic [1:0]    s_q, s_d;
    logic [1:0]    idx_q, idx_d;
    logic          push, pop, xfer, fifo_nempty;
    logic [WW+1:0] head;

    assign ser_if.in_ready  = (cnt_q != 2'd2);
    assign push             = ser_if.in_valid && ser_if.in_ready;
    assign fifo_nempty      = (cnt_q != 2'd0);
    assign head             = mem_q[rd_ptr_q];
    assign xfer             = (state_q == EMIT) && ser_if.out_ready;

    assign ser_if.out_valid = (state_q == EMIT);
    assign ser_if.out_data  = word_q[WIDTH-1:0];
    assign ser_if.out_s     = s_q;
    assign ser_if.out_idx   = idx_q;

    always_comb begin
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // The word register shifts right so the current element always sits in the low bits.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        s_d     = s_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_nempty) begin
                    pop     = 1'b1;
                    word_d  = head[WW-1:0];
                    s_d     = head[WW+1:WW];
                    idx_d   = 2'd0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (xfer) begin
                    if (idx_q != s_q) begin
                        idx_d  = idx_q + 2'd1;
                        word_d = word_q >> WIDTH;
                    end else if (fifo_nempty) begin
                        pop    = 1'b1;
                        word_d = head[WW-1:0];
                        s_d    = head[WW+1:WW];
                        idx_d  = 2'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            state_q  <= IDLE;
            word_q   <= '0;
            s_q      <= 2'd0;
            idx_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {ser_if.in_s, ser_if.in_data};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q   <= cnt_d;
            state_q <= state_d;
            word_q  <= word_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
        end
    end

`ifdef SERIALIZER_LAST_EN
    logic last_q, last_d;

    assign last_d          = (state_d == EMIT) && (idx_d == s_d);
    assign ser_if.out_last = last_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_merge_serializer.sv
// Directed bench for merge_serializer (WIDTH=3): vector table plus hand sequences for
// random back-pressure and mid-word reset.
module tb_merge_serializer;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    merge_serializer_if #(.WIDTH(3)) bus ();

    merge_serializer #(.WIDTH(3)) dut (
        .clk    (clk),
        .rst    (rst),
        .ser_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ivld;
        logic [11:0] idat;
        logic [1:0]  is;
        logic        ordy;
        logic        e_irdy;
        logic        e_ovld;
        logic [2:0]  e_dat;
        logic [1:0]  e_s;
        logic [1:0]  e_idx;
        logic        e_last;
    } vec_t;

    vec_t vecs[$];

    logic [11:0] mw [3];
    logic [1:0]  ms [3];
    logic [2:0]  ed [8];
    logic [1:0]  es [8];
    logic [1:0]  ei [8];

    function automatic vec_t mk(input logic ivld, input logic [11:0] idat, input logic [1:0] is,
                                input logic ordy, input logic irdy, input logic ovld,
                                input logic [2:0] dat, input logic [1:0] s, input logic [1:0] idx,
                                input logic last);
        vec_t v;
        v.ivld = ivld; v.idat = idat; v.is = is; v.ordy = ordy;
        v.e_irdy = irdy; v.e_ovld = ovld; v.e_dat = dat; v.e_s = s; v.e_idx = idx; v.e_last = last;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " out_valid"}, bus.out_valid, 0);
        check({tag, " out_data"},  bus.out_data,  0);
        check({tag, " out_s"},     bus.out_s,     0);
        check({tag, " out_idx"},   bus.out_idx,   0);
`ifdef SERIALIZER_LAST_EN
        check({tag, " out_last"},  bus.out_last,  0);
`endif
    endtask

    initial begin
        logic       irdy_s, ovld_s;
        logic [2:0] od_s;
        logic [1:0] os_s, oi_s;
        int         wi, ne;

        checks = 0;
        errors = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_s      = 2'd0;
        bus.out_ready = 1'b0;

        // QAM16 word 5,2,7,1
        vecs.push_back(mk(1, 12'h3D5, 1, 1,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 5, 1, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 2, 1, 1, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 0, 0, 0, 0, 0));
        // QPSK words 1..4, upper elements filled with 7s that must be discarded
        vecs.push_back(mk(1, 12'hFF9, 0, 1,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'hFFA, 0, 1,  1, 1, 1, 0, 0, 1));
        vecs.push_back(mk(1, 12'hFFB, 0, 1,  1, 1, 2, 0, 0, 1));
        vecs.push_back(mk(1, 12'hFFC, 0, 1,  1, 1, 3, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 4, 0, 0, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 0, 0, 0, 0, 0));
        // Three QAM256 words under back-pressure; fourth offer is refused
        vecs.push_back(mk(1, 12'h8D1, 3, 0,  1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 12'h1F5, 3, 0,  1, 1, 1, 3, 0, 0));
        vecs.push_back(mk(1, 12'hD0B, 3, 0,  0, 1, 1, 3, 0, 0));
        vecs.push_back(mk(1, 12'h777, 3, 0,  0, 1, 1, 3, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  0, 1, 2, 3, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  0, 1, 3, 3, 2, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  0, 1, 4, 3, 3, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 5, 3, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 6, 3, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 7, 3, 2, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 0, 3, 3, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 3, 3, 0, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 1, 3, 1, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 4, 3, 2, 0));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 1, 6, 3, 3, 1));
        vecs.push_back(mk(0, 12'h000, 0, 1,  1, 0, 0, 0, 0, 0));

        // Mixed QAM64 (6,5,4), QPSK (3), QAM256 (1,7,0,2)
        mw[0] = 12'hF2E; ms[0] = 2'd2;
        mw[1] = 12'hFFB; ms[1] = 2'd0;
        mw[2] = 12'h439; ms[2] = 2'd3;
        ed[0] = 6; es[0] = 2; ei[0] = 0;
        ed[1] = 5; es[1] = 2; ei[1] = 1;
        ed[2] = 4; es[2] = 2; ei[2] = 2;
        ed[3] = 3; es[3] = 0; ei[3] = 0;
        ed[4] = 1; es[4] = 3; ei[4] = 0;
        ed[5] = 7; es[5] = 3; ei[5] = 1;
        ed[6] = 0; es[6] = 3; ei[6] = 2;
        ed[7] = 2; es[7] = 3; ei[7] = 3;

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        #1;
        check("reset in_ready", bus.in_ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            bus.in_valid  = vecs[i].ivld;
            bus.in_data   = vecs[i].idat;
            bus.in_s      = vecs[i].is;
            bus.out_ready = vecs[i].ordy;
            @(posedge clk);
            #1;
            check($sformatf("v%0d in_ready", i),  bus.in_ready,  vecs[i].e_irdy);
            check($sformatf("v%0d out_valid", i), bus.out_valid, vecs[i].e_ovld);
            if (vecs[i].e_ovld) begin
                check($sformatf("v%0d out_data", i), bus.out_data, vecs[i].e_dat);
                check($sformatf("v%0d out_s", i),    bus.out_s,    vecs[i].e_s);
                check($sformatf("v%0d out_idx", i),  bus.out_idx,  vecs[i].e_idx);
            end
`ifdef SERIALIZER_LAST_EN
            check($sformatf("v%0d out_last", i), bus.out_last, vecs[i].e_last);
`endif
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Random 50% back-pressure with a scoreboard of expected elements
        wi = 0;
        ne = 0;
        for (int cyc = 0; cyc < 200 && ne < 8; cyc++) begin
            bus.in_valid  = (wi < 3);
            bus.in_data   = (wi < 3) ? mw[wi] : 12'h000;
            bus.in_s      = (wi < 3) ? ms[wi] : 2'd0;
            bus.out_ready = 1'($urandom_range(0, 1));
            irdy_s = bus.in_ready;
            ovld_s = bus.out_valid;
            od_s   = bus.out_data;
            os_s   = bus.out_s;
            oi_s   = bus.out_idx;
            if (ovld_s && bus.out_ready) begin
                check($sformatf("mix e%0d data", ne), od_s, ed[ne]);
                check($sformatf("mix e%0d s", ne),    os_s, es[ne]);
                check($sformatf("mix e%0d idx", ne),  oi_s, ei[ne]);
`ifdef SERIALIZER_LAST_EN
                check($sformatf("mix e%0d last", ne), bus.out_last, (ei[ne] == es[ne]));
`endif
                ne++;
            end
            @(posedge clk);
            #1;
            if (bus.in_valid && irdy_s) wi++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (bus.out_valid) ne++;
            @(posedge clk);
            #1;
        end
        check("mix element count", ne, 8);
        check("mix words accepted", wi, 3);

        // Reset while idx=2 of a QAM256 word with one word queued
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 12'h8D1;
        bus.in_s      = 2'd3;
        @(posedge clk);
        #1;
        bus.in_data   = 12'h1F5;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("pre-reset out_idx",  bus.out_idx,  2);
        check("pre-reset out_data", bus.out_data, 3);
        #1;
        rst = 1'b1;
        #1;
        check_zero_outputs("async reset");
        #2;
        rst = 1'b0;
        #1;
        check("post-reset in_ready",  bus.in_ready,  1);
        check("post-reset out_valid", bus.out_valid, 0);
        bus.in_valid = 1'b1;
        bus.in_data  = 12'hFFD;
        bus.in_s     = 2'd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("post-reset latency valid", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("post-reset qpsk valid", bus.out_valid, 1);
        check("post-reset qpsk data",  bus.out_data,  5);
        check("post-reset qpsk idx",   bus.out_idx,   0);
        check("post-reset qpsk s",     bus.out_s,     0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("no stale c%0d", c), bus.out_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
